// File: rtl/slurm32_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and execute-stage load/store.
// Data requests win by default; a pending fetch is forced through after STARVE_LIMIT data grants.
module slurm32_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    output logic        fetch_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_mask,
    output logic [31:0] ex_rdata,
    output logic        ex_done,
    output logic        stall,
    output logic        bus_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] streak, streak_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n;
    logic [MW-1:0] mem_mask_n;
    logic          mem_rd_n, mem_wr_n;
    logic [DW-1:0] fetch_data_n, ex_rdata_n;
    logic          fetch_valid_n, ex_done_n, bus_err_n;

    logic          data_req;
    logic          grant_fetch;
    logic          timed_out;
    logic [DW-1:0] done_data;

    assign data_req    = ex_load | ex_store;
    assign grant_fetch = fetch_req & (~data_req | (streak == SW'(STARVE_LIMIT)));
    assign timed_out   = (wait_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign done_data   = mem_ready ? mem_rdata : {DW{1'b1}};

    assign stall = data_req & ~ex_done;

    // State and registered-output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            wait_cnt    <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_mask    <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            fetch_data  <= '0;
            ex_rdata    <= '0;
            fetch_valid <= 1'b0;
            ex_done     <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state       <= state_n;
            streak      <= streak_n;
            wait_cnt    <= wait_cnt_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            mem_mask    <= mem_mask_n;
            mem_rd      <= mem_rd_n;
            mem_wr      <= mem_wr_n;
            fetch_data  <= fetch_data_n;
            ex_rdata    <= ex_rdata_n;
            fetch_valid <= fetch_valid_n;
            ex_done     <= ex_done_n;
            bus_err     <= bus_err_n;
        end
    end

    // Next-state, arbitration and completion logic
    always_comb begin
        state_n       = state;
        streak_n      = streak;
        wait_cnt_n    = wait_cnt;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        mem_mask_n    = mem_mask;
        mem_rd_n      = mem_rd;
        mem_wr_n      = mem_wr;
        fetch_data_n  = fetch_data;
        ex_rdata_n    = ex_rdata;
        fetch_valid_n = 1'b0;
        ex_done_n     = 1'b0;
        bus_err_n     = 1'b0;

        unique case (state)
            IDLE: begin
                wait_cnt_n = '0;
                if (grant_fetch) begin
                    mem_addr_n  = fetch_addr;
                    mem_wdata_n = '0;
                    mem_mask_n  = {MW{1'b1}};
                    mem_rd_n    = 1'b1;
                    mem_wr_n    = 1'b0;
                    streak_n    = '0;
                    state_n     = FETCH;
                end else if (data_req) begin
                    // A simultaneous load+store is issued as a store
                    mem_addr_n  = ex_addr;
                    mem_wdata_n = ex_wdata;
                    mem_mask_n  = ex_mask;
                    mem_rd_n    = ~ex_store;
                    mem_wr_n    = ex_store;
                    if (fetch_req && (streak != SW'(STARVE_LIMIT))) begin
                        streak_n = streak + SW'(1);
                    end
                    state_n     = DATA;
                end
            end
            FETCH, DATA: begin
                if (mem_ready || timed_out) begin
                    mem_rd_n  = 1'b0;
                    mem_wr_n  = 1'b0;
                    bus_err_n = ~mem_ready;
                    if (state == FETCH) begin
                        fetch_data_n  = done_data;
                        fetch_valid_n = 1'b1;
                    end else begin
                        ex_rdata_n = done_data;
                        ex_done_n  = 1'b1;
                    end
                    state_n = DONE;
                end else begin
                    wait_cnt_n = wait_cnt + WW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_slurm32_mem_arbiter.sv
// Directed bench for slurm32_mem_arbiter: transaction-level model compared every cycle,
// plus literal expectations for the headline scenarios.
module tb_slurm32_mem_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, ex_load, ex_store;
    logic [31:0] fetch_addr, ex_addr, ex_wdata;
    logic [3:0]  ex_mask;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic [31:0] fetch_data, ex_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        fetch_valid, ex_done, stall, bus_err, mem_rd, mem_wr;

    slurm32_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .ex_load(ex_load), .ex_store(ex_store), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_mask(ex_mask),
        .ex_rdata(ex_rdata), .ex_done(ex_done), .stall(stall), .bus_err(bus_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: ready after resp_lat strobe cycles (negative = never)
    int          resp_lat   = 0;
    logic [31:0] resp_data  = 32'h0;
    bit          junk_ready = 1'b0;
    int          rk         = 0;
    always @(posedge clk) begin
        #1;
        if (mem_rd | mem_wr) begin
            mem_ready = (resp_lat >= 0) && (rk == resp_lat);
            mem_rdata = mem_ready ? resp_data : 32'h0BAD0BAD;
            rk++;
        end else begin
            rk        = 0;
            mem_ready = junk_ready;
            mem_rdata = 32'h5555AAAA;
        end
    end

    // Transaction model: a grant books n strobe cycles plus one done cycle
    int          m_left = 0, m_streak = 0;
    bit          m_fetch = 0, m_timeout = 0;
    logic [31:0] m_data = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_fetch_data = 0, e_ex_rdata = 0;
    logic [3:0]  e_mask = 0;
    bit          e_mask_chk = 0, e_rd = 0, e_wr = 0, e_fv = 0, e_ed = 0, e_err = 0;

    task automatic book(input bit is_fetch);
        int n;
        m_fetch   = is_fetch;
        m_timeout = (resp_lat < 0) || (resp_lat >= TMO);
        n         = m_timeout ? TMO : resp_lat + 1;
        m_left    = n + 1;
        m_data    = resp_data;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_streak = 0;
            e_rd = 0; e_wr = 0; e_fv = 0; e_ed = 0; e_err = 0;
            e_fetch_data = 0; e_ex_rdata = 0;
        end else if (m_left == 0) begin
            e_fv = 0; e_ed = 0; e_err = 0;
            if (fetch_req && (!(ex_load || ex_store) || m_streak == STARVE)) begin
                e_addr = fetch_addr; e_mask = 4'hF; e_mask_chk = 1;
                e_rd = 1; e_wr = 0; m_streak = 0;
                book(1'b1);
            end else if (ex_load || ex_store) begin
                e_addr = ex_addr;
                if (ex_store) begin
                    e_wdata = ex_wdata; e_mask = ex_mask; e_mask_chk = 1; e_wr = 1; e_rd = 0;
                end else begin
                    e_mask_chk = 0; e_rd = 1; e_wr = 0;
                end
                if (fetch_req && m_streak < STARVE) m_streak++;
                book(1'b0);
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                e_rd = 0; e_wr = 0; e_err = m_timeout;
                if (m_fetch) begin
                    e_fv = 1; e_fetch_data = m_timeout ? 32'hFFFFFFFF : m_data;
                end else begin
                    e_ed = 1; e_ex_rdata = m_timeout ? 32'hFFFFFFFF : m_data;
                end
            end else if (m_left == 0) begin
                e_fv = 0; e_ed = 0; e_err = 0;
            end
        end
    end

    // Per-cycle compare and activity counters
    bit   cmp_en = 0;
    int   rd_cyc = 0, wr_cyc = 0, ed_cnt = 0, fv_cnt = 0, err_cnt = 0;
    byte  glog[$];
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_rd", 32'(mem_rd), 32'(e_rd));
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
            chk("ex_done", 32'(ex_done), 32'(e_ed));
            chk("bus_err", 32'(bus_err), 32'(e_err));
            chk("stall", 32'(stall), 32'((ex_load | ex_store) & ~e_ed));
            chk("fetch_data", fetch_data, e_fetch_data);
            chk("ex_rdata", ex_rdata, e_ex_rdata);
            if (e_rd || e_wr) chk("mem_addr", mem_addr, e_addr);
            if ((e_rd || e_wr) && e_mask_chk) chk("mem_mask", 32'(mem_mask), 32'(e_mask));
            if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
            rd_cyc  += int'(mem_rd);
            wr_cyc  += int'(mem_wr);
            ed_cnt  += int'(ex_done);
            fv_cnt  += int'(fetch_valid);
            err_cnt += int'(bus_err);
            if ((mem_rd | mem_wr) && !prev_strobe)
                glog.push_back(mem_addr == 32'h4000 ? 8'h46 : 8'h44);
            prev_strobe = mem_rd | mem_wr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 ex_done, 1 fetch_valid, 2 any strobe
    task automatic wait_for(input int sel, input int limit, input string nm);
        bit hit = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((sel == 0 && ex_done === 1'b1) || (sel == 1 && fetch_valid === 1'b1) ||
                (sel == 2 && (mem_rd | mem_wr) === 1'b1)) begin
                hit = 1;
                break;
            end
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    int    s_rd, s_wr, s_ed, s_err, gbase;
    string pat;

    initial begin
        rst = 1; fetch_req = 0; ex_load = 0; ex_store = 0;
        fetch_addr = 0; ex_addr = 0; ex_wdata = 0; ex_mask = 0;
        tick(); tick();
        cmp_en = 1;
        @(negedge clk);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_fetch_data", fetch_data, 32'd0);
        tick();
        rst = 0;

        // Load with immediate ready
        resp_lat = 0; resp_data = 32'hDEADBEEF; ex_addr = 32'h100; ex_load = 1;
        s_rd = rd_cyc;
        wait_for(0, 20, "load_wait");
        chk("load_rdata", ex_rdata, 32'hDEADBEEF);
        chk("load_stall", 32'(stall), 32'd0);
        tick(); ex_load = 0; tick(); tick();
        chk("load_rd_cycles", 32'(rd_cyc - s_rd), 32'd1);

        // Store with three wait cycles
        resp_lat = 3; resp_data = 32'h0; ex_addr = 32'h200; ex_wdata = 32'h12345678;
        ex_mask = 4'b0011; ex_store = 1;
        s_wr = wr_cyc; s_ed = ed_cnt;
        wait_for(0, 30, "store_wait");
        tick(); ex_store = 0; tick(); tick();
        chk("store_wr_cycles", 32'(wr_cyc - s_wr), 32'd4);
        chk("store_done_pulses", 32'(ed_cnt - s_ed), 32'd1);

        // Load and store together resolve to a store
        resp_lat = 1; resp_data = 32'h00C0FFEE; ex_addr = 32'h300; ex_wdata = 32'hA5A5A5A5;
        ex_mask = 4'b1100; ex_load = 1; ex_store = 1;
        s_rd = rd_cyc; s_wr = wr_cyc;
        wait_for(0, 20, "both_wait");
        tick(); ex_load = 0; ex_store = 0; tick(); tick();
        chk("both_wr_cycles", 32'(wr_cyc - s_wr), 32'd2);
        chk("both_rd_cycles", 32'(rd_cyc - s_rd), 32'd0);

        // Stray mem_ready outside a transfer is ignored
        junk_ready = 1;
        tick(); tick(); tick();
        resp_lat = 2; resp_data = 32'hCAFEF00D; fetch_addr = 32'h40; fetch_req = 1;
        s_rd = rd_cyc;
        wait_for(1, 20, "fetch_wait");
        chk("fetch_rdata", fetch_data, 32'hCAFEF00D);
        chk("fetch_no_err", 32'(bus_err), 32'd0);
        tick(); fetch_req = 0; junk_ready = 0; tick(); tick();
        chk("fetch_rd_cycles", 32'(rd_cyc - s_rd), 32'd3);

        // Timeout: no ready ever
        resp_lat = -1; fetch_addr = 32'h80; fetch_req = 1;
        s_rd = rd_cyc; s_err = err_cnt;
        wait_for(1, 300, "tmo_wait");
        chk("tmo_bus_err", 32'(bus_err), 32'd1);
        chk("tmo_rdata", fetch_data, 32'hFFFFFFFF);
        tick(); fetch_req = 0; tick(); tick();
        chk("tmo_rd_cycles", 32'(rd_cyc - s_rd), 32'd255);
        chk("tmo_err_pulses", 32'(err_cnt - s_err), 32'd1);

        // Ready on the last wait cycle still completes normally
        resp_lat = 254; resp_data = 32'h13579BDF; fetch_addr = 32'h84; fetch_req = 1;
        s_rd = rd_cyc;
        wait_for(1, 300, "edge_wait");
        chk("edge_no_err", 32'(bus_err), 32'd0);
        chk("edge_rdata", fetch_data, 32'h13579BDF);
        tick(); fetch_req = 0; tick(); tick();
        chk("edge_rd_cycles", 32'(rd_cyc - s_rd), 32'd255);

        // Reset in the middle of a load, then re-grant of the held request
        resp_lat = -1; ex_addr = 32'h500; ex_load = 1;
        s_ed = ed_cnt; s_err = err_cnt;
        wait_for(2, 10, "rst_strobe_wait");
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; resp_lat = 0; resp_data = 32'h600DF00D;
        @(negedge clk);
        chk("rst_strobe_drop", 32'(mem_rd), 32'd0);
        chk("rst_no_done", 32'(ex_done), 32'd0);
        wait_for(0, 20, "regrant_wait");
        chk("regrant_rdata", ex_rdata, 32'h600DF00D);
        tick(); ex_load = 0; tick(); tick();
        chk("rst_done_pulses", 32'(ed_cnt - s_ed), 32'd1);
        chk("rst_err_pulses", 32'(err_cnt - s_err), 32'd0);

        // Fairness: four data grants then one fetch, repeating
        rst = 1; tick(); rst = 0;
        fetch_addr = 32'h4000; ex_addr = 32'h8000; resp_lat = 0; resp_data = 32'h77;
        gbase = glog.size();
        fetch_req = 1; ex_load = 1;
        for (int i = 0; i < 100 && glog.size() < gbase + 10; i++) tick();
        chk("fair_grant_count", 32'(glog.size() >= gbase + 10), 32'd1);
        pat = "DDDDFDDDDF";
        if (glog.size() >= gbase + 10) begin
            for (int i = 0; i < 10; i++) chk("fair_grant", 32'(glog[gbase + i]), 32'(pat[i]));
        end
        fetch_req = 0; ex_load = 0;
        for (int i = 0; i < 6; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slurm32_mem_arbiter.md
SLURM32_MEM_ARBITER -- requirements
Module: slurm32_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive data grants while a fetch is pending.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum wait cycles for mem_ready before abort (8-bit count).
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 fetch_req  in  1  fetch request, held high until fetch_valid is seen.
REQ-006 fetch_addr  in  32  fetch word address, stable while fetch_req is high.
REQ-007 fetch_data  out  32  read data for fetch, valid with fetch_valid.
REQ-008 fetch_valid  out  1  one-cycle fetch completion pulse.
REQ-009 ex_load / ex_store  in  1 each  execute-stage load / store request, held until ex_done.
REQ-010 ex_addr  in  32; ex_wdata  in  32; ex_mask  in  4  execute address, store data, byte mask.
REQ-011 ex_rdata  out  32  load data, valid with ex_done.
REQ-012 ex_done  out  1  one-cycle data completion pulse.
REQ-013 stall  out  1  combinational: (ex_load | ex_store) & ~ex_done.
REQ-014 bus_err  out  1  one-cycle pulse coincident with the done/valid of a timed-out access.
REQ-015 mem_addr  out  32; mem_wdata  out  32; mem_mask  out  4  registered bus address, write data, mask.
REQ-016 mem_rd / mem_wr  out  1 each  registered read / write strobes.
REQ-017 mem_rdata  in  32; mem_ready  in  1  bus read data and completion.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DATA, DONE.
REQ-019 In IDLE with any request, the FSM SHALL latch the winner's address, data and mask to mem_* and enter FETCH or DATA on the next edge.
REQ-020 Arbitration SHALL favour data: DATA is granted when ex_load|ex_store, unless fetch_req is high and streak == STARVE_LIMIT, in which case FETCH is granted.
REQ-021 streak SHALL increment on each data grant made while fetch_req is high, clear on any fetch grant, and saturate at STARVE_LIMIT.
REQ-022 Simultaneous ex_load and ex_store SHALL be treated as a store.
REQ-023 FETCH and loads SHALL assert mem_rd; stores SHALL assert mem_wr with mem_mask = ex_mask; fetch reads SHALL drive mem_mask = 4'hF.
REQ-024 Strobes SHALL hold constant throughout FETCH/DATA and deassert on the edge leaving that state.
REQ-025 On mem_ready sampled high in FETCH/DATA, the FSM SHALL capture mem_rdata to fetch_data or ex_rdata and enter DONE.
REQ-026 In DONE (exactly one cycle), the matching fetch_valid or ex_done SHALL be high, no grant SHALL be taken, and the next state SHALL be IDLE.
REQ-027 Minimum latency SHALL be: request sampled at edge E, strobe high after E, mem_ready in that cycle, done high in the cycle after E+1.
REQ-028 Wait cycles SHALL be counted in FETCH/DATA; when the count reaches TIMEOUT_CYCLES without mem_ready, the FSM SHALL enter DONE with bus_err=1 and rdata=32'hFFFFFFFF.
REQ-029 mem_ready SHALL be ignored in IDLE and DONE.
REQ-030 fetch_data and ex_rdata SHALL hold their values until the next completion of the same port.

Reset
REQ-031 While RST is high on an edge: state IDLE, streak and wait count 0, all registered outputs 0.
REQ-032 Reset mid-transaction SHALL drop the strobes on that edge with no done/valid/bus_err pulse.

Verification
REQ-033 Load: ex_load=1, ex_addr=0x100, mem_ready=1 immediately, mem_rdata=0xDEADBEEF -> mem_rd=1 one cycle, then ex_done=1, ex_rdata=0xDEADBEEF, stall falls.
REQ-034 Store: ex_store=1, ex_mask=4'b0011, ex_wdata=0x12345678, mem_ready after 3 cycles -> mem_wr held 4 cycles with mem_mask=0011, then a single ex_done pulse.
REQ-035 Fairness: fetch_req and data requests continuously high -> grant pattern 4 DATA, 1 FETCH, repeating.
REQ-036 Timeout: fetch_req=1, mem_ready never asserted -> after 255 wait cycles, fetch_valid=1, bus_err=1, fetch_data=0xFFFFFFFF.
REQ-037 Reset mid-DATA: RST high while mem_rd=1 -> strobes 0 next edge, no ex_done; after RST low, a held request is re-granted.
